byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter REV_ORDER, default 0; 0 = emit b1,b2,b3,b4; 1 = emit b4,b3,b2,b1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports b1,b2,b3,b4  input  8 each  word bytes from the splitting stage (b1 = most significant lane).
REQ-005 SHALL have port in_valid  input  1  upstream word present on b1..b4.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port out_data  output  8  current byte.
REQ-008 SHALL have port out_valid  output  1  out_data is valid.
REQ-009 SHALL have port out_ready  input  1  downstream consumes byte this cycle.
REQ-010 SHALL have port out_last  output  1  high with the 4th byte of a word.
REQ-011 SHALL have port out_idx  output  2  emission position 0..3 of current byte.
REQ-012 SHALL have port word_cnt  output  8  count of fully emitted words, modulo 256.

Function
REQ-013 SHALL implement two states: IDLE (no word held) and SEND (word held, bytes pending).
REQ-014 SHALL define accept = in_valid & in_ready; byte handshake = out_valid & out_ready.
REQ-015 SHALL drive in_ready = 1 in IDLE; in SEND, in_ready = out_ready & (out_idx == 3), a combinational path from out_ready.
REQ-016 On accept, SHALL latch b1..b4 into a 32-bit holding register, set out_idx = 0, enter SEND; first byte valid the next cycle (1-cycle latency).
REQ-017 In SEND, out_valid SHALL be 1; out_data SHALL be the held byte selected by out_idx per REV_ORDER; in IDLE out_valid = 0, out_data = 0.
REQ-018 out_data, out_idx, out_last SHALL stay stable while out_valid & ~out_ready (backpressure hold).
REQ-019 On a byte handshake with out_idx < 3, SHALL increment out_idx; on a byte handshake with out_idx == 3, SHALL increment word_cnt and either load the new word (if in_valid, back-to-back, out_idx = 0, stay SEND) or return to IDLE.
REQ-020 SHALL make back-to-back words stream with no bubble: 4 words in 16 consecutive cycles when in_valid and out_ready are held high.
REQ-021 out_last SHALL equal out_valid & (out_idx == 3).
REQ-022 word_cnt SHALL wrap 255 -> 0 without any flag.
REQ-023 SHALL ignore b1..b4 and in_valid whenever in_ready = 0; a held word SHALL never be overwritten before its 4th byte handshakes.

Reset
REQ-024 When reset = 1 at a rising edge, SHALL enter IDLE, clear holding register, out_idx = 0, word_cnt = 0; outputs then out_valid = 0, out_data = 0, out_last = 0, in_ready = 1.
REQ-025 Reset SHALL take priority over any simultaneous accept or byte handshake; a partially emitted word SHALL be discarded, not resumed.

Verification
REQ-026 Single word b1..b4 = 12,34,56,78 (hex), REV_ORDER=0, out_ready=1 -> out_data 12,34,56,78 on cycles 1-4 after accept, out_last only on 78, word_cnt 0 -> 1.
REQ-027 Same word with REV_ORDER=1 -> out_data 78,56,34,12, out_idx 0,1,2,3.
REQ-028 out_ready low for 3 cycles while byte 34 is presented -> 34 held stable 3 cycles, in_ready = 0, no byte skipped or duplicated.
REQ-029 in_valid held high with 3 distinct words, out_ready=1 -> 12 consecutive valid bytes, no gap, in_ready pulses on each out_last cycle, word_cnt = 3.
REQ-030 reset asserted after 2nd byte of a word -> next cycle out_valid = 0, word_cnt = 0, in_ready = 1; next accepted word starts at out_idx 0.
REQ-031 256 words streamed -> word_cnt returns to 0.

Source files
------------

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
//   Takes a 32-bit word presented as four byte lanes (b1 = most significant)
//   and emits it one byte per handshake on a valid/ready byte stream.
//   A new word is accepted either from IDLE or in the same cycle the 4th byte
//   of the held word handshakes, so back-to-back words stream with no bubble.
//
// Parameters
//   REV_ORDER : 0 = emit b1,b2,b3,b4 ; nonzero = emit b4,b3,b2,b1
//
// Ports
//   clk       in   1  clock, all state updates on the rising edge
//   reset     in   1  synchronous active-high reset
//   b1..b4    in   8  word byte lanes (b1 = MS lane)
//   in_valid  in   1  upstream word present on b1..b4
//   in_ready  out  1  word accepted this cycle when in_valid is also high
//   out_data  out  8  current byte (0 when idle)
//   out_valid out  1  out_data is valid
//   out_ready in   1  downstream consumes the byte this cycle
//   out_last  out  1  high with the 4th byte of a word
//   out_idx   out  2  emission position 0..3 of the current byte
//   word_cnt  out  8  count of fully emitted words, modulo 256
// -----------------------------------------------------------------------------
module byte_serializer #(
  parameter int unsigned REV_ORDER = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [7:0] b3,
  input  logic [7:0] b4,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [1:0] out_idx,
  output logic [7:0] word_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_hold;
  logic [1:0]  r_idx;
  logic [7:0]  r_word_cnt;

  logic        w_send;
  logic        w_idx_last;
  logic        w_accept;
  logic [1:0]  w_lane;

  assign w_send     = (r_state == ST_SEND);
  assign w_idx_last = (r_idx == 2'd3);

  // While sending, a new word can only enter as the final byte leaves, which
  // keeps the held word intact until its 4th byte has handshaken.
  assign in_ready = ~w_send | (out_ready & w_idx_last);
  assign w_accept = in_valid & in_ready;

  // Lane 3 is b1 (bits 31:24). Forward order walks lanes 3..0, reverse 0..3.
  assign w_lane = (REV_ORDER != 0) ? r_idx : ~r_idx;

  assign out_valid = w_send;
  assign out_data  = w_send ? r_hold[{w_lane, 3'b000} +: 8] : 8'h00;
  assign out_last  = w_send & w_idx_last;
  assign out_idx   = r_idx;
  assign word_cnt  = r_word_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold     <= 32'h0;
      r_idx      <= 2'd0;
      r_word_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_hold  <= {b1, b2, b3, b4};
            r_idx   <= 2'd0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (w_idx_last) begin
              r_word_cnt <= r_word_cnt + 8'd1;
              r_idx      <= 2'd0;
              if (w_accept) begin
                r_hold <= {b1, b2, b3, b4};
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_byte_serializer
//   Directed bench for byte_serializer. Two instances share all inputs:
//   dut_f (REV_ORDER=0) and dut_r (REV_ORDER=1). Inputs change and outputs
//   are sampled on the falling edge; state changes on the rising edge.
// -----------------------------------------------------------------------------
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] b1, b2, b3, b4;
  logic       in_valid;
  logic       out_ready;

  logic       f_in_ready, f_out_valid, f_out_last;
  logic [7:0] f_out_data, f_word_cnt;
  logic [1:0] f_out_idx;
  logic       r_in_ready, r_out_valid, r_out_last;
  logic [7:0] r_out_data, r_word_cnt;
  logic [1:0] r_out_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  byte_serializer #(.REV_ORDER(0)) dut_f (
    .clk(clk), .reset(reset),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .in_valid(in_valid), .in_ready(f_in_ready),
    .out_data(f_out_data), .out_valid(f_out_valid), .out_ready(out_ready),
    .out_last(f_out_last), .out_idx(f_out_idx), .word_cnt(f_word_cnt)
  );

  byte_serializer #(.REV_ORDER(1)) dut_r (
    .clk(clk), .reset(reset),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .in_valid(in_valid), .in_ready(r_in_ready),
    .out_data(r_out_data), .out_valid(r_out_valid), .out_ready(out_ready),
    .out_last(r_out_last), .out_idx(r_out_idx), .word_cnt(r_word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one presented byte on both instances.
  task automatic chk_byte(input string tag, input logic [7:0] exp_f, input logic [7:0] exp_r,
                          input logic [1:0] idx, input logic ready_exp);
    chk({tag, " valid"},    {31'd0, f_out_valid}, 32'd1);
    chk({tag, " data_f"},   {24'd0, f_out_data},  {24'd0, exp_f});
    chk({tag, " data_r"},   {24'd0, r_out_data},  {24'd0, exp_r});
    chk({tag, " idx_f"},    {30'd0, f_out_idx},   {30'd0, idx});
    chk({tag, " idx_r"},    {30'd0, r_out_idx},   {30'd0, idx});
    chk({tag, " last"},     {31'd0, f_out_last},  {31'd0, (idx == 2'd3)});
    chk({tag, " in_ready"}, {31'd0, f_in_ready},  {31'd0, ready_exp});
    $display("byte %s: data_f=%h data_r=%h idx=%0d last=%0b in_ready=%0b cnt=%0d",
             tag, f_out_data, r_out_data, f_out_idx, f_out_last, f_in_ready, f_word_cnt);
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] cnt);
    chk({tag, " valid"},    {31'd0, f_out_valid}, 32'd0);
    chk({tag, " valid_r"},  {31'd0, r_out_valid}, 32'd0);
    chk({tag, " data"},     {24'd0, f_out_data},  32'd0);
    chk({tag, " last"},     {31'd0, f_out_last},  32'd0);
    chk({tag, " in_ready"}, {31'd0, f_in_ready},  32'd1);
    chk({tag, " cnt_f"},    {24'd0, f_word_cnt},  {24'd0, cnt});
    chk({tag, " cnt_r"},    {24'd0, r_word_cnt},  {24'd0, cnt});
    $display("idle %s: valid=%0b in_ready=%0b cnt=%0d", tag, f_out_valid, f_in_ready, f_word_cnt);
  endtask

  task automatic set_word(input logic [31:0] w);
    {b1, b2, b3, b4} = w;
  endtask

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [3];
    int          nvalid;

    words[0] = 32'h0102_0304;
    words[1] = 32'hA0B0_C0D0;
    words[2] = 32'h1122_3344;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; set_word(32'h0);
    repeat (2) @(negedge clk);
    chk_idle("reset", 8'd0);
    reset = 1'b0;

    // Single word, full throughput.
    set_word(32'h1234_5678); in_valid = 1'b1;
    @(negedge clk); chk_byte("w1b0", 8'h12, 8'h78, 2'd0, 1'b0); in_valid = 1'b0;
    @(negedge clk); chk_byte("w1b1", 8'h34, 8'h56, 2'd1, 1'b0);
    @(negedge clk); chk_byte("w1b2", 8'h56, 8'h34, 2'd2, 1'b0);
    @(negedge clk); chk_byte("w1b3", 8'h78, 8'h12, 2'd3, 1'b1);
    @(negedge clk); chk_idle("w1end", 8'd1);

    // Backpressure on byte 34; a competing word must be ignored meanwhile.
    set_word(32'h1234_5678); in_valid = 1'b1;
    @(negedge clk); chk_byte("bp0", 8'h12, 8'h78, 2'd0, 1'b0);
    set_word(32'hEEEE_EEEE);
    @(negedge clk); chk_byte("bp1", 8'h34, 8'h56, 2'd1, 1'b0); out_ready = 1'b0;
    @(negedge clk); chk_byte("bp1h1", 8'h34, 8'h56, 2'd1, 1'b0);
    @(negedge clk); chk_byte("bp1h2", 8'h34, 8'h56, 2'd1, 1'b0);
    @(negedge clk); chk_byte("bp1h3", 8'h34, 8'h56, 2'd1, 1'b0);
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk); chk_byte("bp2", 8'h56, 8'h34, 2'd2, 1'b0);
    @(negedge clk); chk_byte("bp3", 8'h78, 8'h12, 2'd3, 1'b1);
    @(negedge clk); chk_idle("bpend", 8'd2);

    // Three words back-to-back with in_valid held high.
    set_word(words[0]); in_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk_byte($sformatf("b2b_w%0d_b%0d", w, i),
                 words[w][31 - 8*i -: 8], words[w][8*i +: 8], i[1:0], (i == 3));
        if (i == 3) begin
          if (w < 2) set_word(words[w + 1]);
          else       in_valid = 1'b0;
        end
      end
    end
    @(negedge clk); chk_idle("b2bend", 8'd5);

    // Reset in the middle of a word discards it.
    set_word(32'hCAFE_BABE); in_valid = 1'b1;
    @(negedge clk); chk_byte("rs0", 8'hCA, 8'hBE, 2'd0, 1'b0); in_valid = 1'b0;
    @(negedge clk); chk_byte("rs1", 8'hFE, 8'hBA, 2'd1, 1'b0);
    @(negedge clk); chk_byte("rs2", 8'hBA, 8'hFE, 2'd2, 1'b0);
    reset = 1'b1; in_valid = 1'b1; set_word(32'h5555_5555);
    @(negedge clk); chk_idle("rsmid", 8'd0);
    reset = 1'b0; set_word(32'h9ABC_DEF0);
    @(negedge clk); chk_byte("rsn0", 8'h9A, 8'hF0, 2'd0, 1'b0); in_valid = 1'b0;
    @(negedge clk); chk_byte("rsn1", 8'hBC, 8'hDE, 2'd1, 1'b0);
    @(negedge clk); chk_byte("rsn2", 8'hDE, 8'hBC, 2'd2, 1'b0);
    @(negedge clk); chk_byte("rsn3", 8'hF0, 8'h9A, 2'd3, 1'b1);
    @(negedge clk); chk_idle("rsnend", 8'd1);

    // 256 words streamed without a gap: counter wraps back to 0.
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    set_word(32'h0F1E_2D3C); in_valid = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (f_out_valid === 1'b1) nvalid++;
      if (k == 1020) begin
        chk("wrap cnt255", {24'd0, f_word_cnt}, 32'd255);
        $display("wrap: cnt=%0d at byte %0d", f_word_cnt, k);
      end
      if (k == 1023) in_valid = 1'b0;
    end
    chk("wrap valid bytes", nvalid, 32'd1024);
    $display("wrap: %0d valid bytes in 1024 cycles", nvalid);
    @(negedge clk); chk_idle("wrapend", 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
